fm_modulator_core: RTL and testbench
====================================

// Module: fm_modulator_core
// PURPOSE
//  FM transmit core; the counterpart of the receive radio core.
//  Takes 32 kHz signed audio through a valid/ready input and interpolates it x R2 to 960 kHz with a 3rd-order CIC.
//  Scales the result into a frequency deviation added to carrier constant K.
//  Drives a full-rate phase accumulator; the accumulator MSB is the 1-bit carrier output.
// PARAMETERS
//  width_dds   32  phase accumulator / frequency word width
//  width_audio 16  audio sample width (signed)
//  R2          30  audio to base-band interpolation ratio
//  dev_shl     8   left shift applied to baseband*dev_gain before adding to K
// PORTS
//  clk          in   1            system clock (240 MHz nominal)
//  reset        in   1            asynchronous, active-low reset
//  en960k       in   1            base-band clock enable, one-cycle pulse
//  en32k        in   1            audio clock enable; always coincides with an en960k pulse
//  audio_in     in   width_audio  signed audio sample
//  audio_valid  in   1            audio_in valid
//  audio_ready  out  1            holding register empty; sample accepted when valid && ready
//  K            in   width_dds    carrier phase constant
//  dev_gain     in   8            unsigned deviation gain
//  phase        out  width_dds    phase accumulator
//  tx_out       out  1            registered phase MSB, the 1-bit carrier
//  underrun     out  1            one-cycle pulse: en32k found no sample
// BEHAVIOUR
//  Reset: all registers cleared asynchronously at any time, mid-operation included.
//   Outputs after reset: audio_ready=1, phase=0, tx_out=0, underrun=0.
//   CIC state, holding register, last sample and freq_word are all 0.
//  Holding register (1 entry):
//   - filled on valid&&ready; ready=0 while full.
//   - on en32k, content moves to the CIC comb input and the register empties.
//  Boundary: en32k, holding register empty, valid=1 in the same cycle:
//   - sample bypasses straight to the comb; no underrun; holding register stays empty.
//  Boundary: en32k, holding register empty, valid=0:
//   - comb reuses the last sample and underrun pulses for 1 cycle.
//  Boundary: en32k with holding register full and valid=1:
//   - register content goes to the comb; the new sample is accepted into the register the same cycle (ready=0 that cycle).
//  CIC interpolator, N=3, internal width W = width_audio + 3*$clog2(R2):
//   - 3 combs (diff delay 1) update on en32k; result registered.
//   - Integrator 1 adds the comb result on the first en960k after en32k; adds 0 on the other R2-1 ticks.
//   - 3 cascaded integrators update on en960k. Two's-complement wrap is intentional, no saturation.
//   - baseband = integ3 >>> S, truncated to width_audio, where S = $clog2(R2**2). DC gain R2^2/2^S (900/1024).
//  Deviation, registered on en960k: freq_word = K + (sext(baseband*$signed({1'b0,dev_gain})) <<< dev_shl), modulo 2^width_dds.
//  Accumulator: phase <= phase + freq_word on every clk. tx_out <= phase[MSB].
//  Latency:
//   - comb output 1 en32k after transfer;
//   - freq_word first reflects a new sample 4 en960k ticks later (3 integrators + deviation register);
//   - tx_out lags phase by 1 clk.
//  K changes take effect on the next en960k.
// CONFIGURATION
//  PREEMPHASIS_EN defined:
//   - sample entering the comb is y = sat16(x + ((x - x_prev) <<< 1)); x_prev = previous comb input.
//   - first-order high-shelf pre-emphasis; x_prev reset to 0.
//   - saturates to [-32768, 32767]; no added latency.
//  PREEMPHASIS_EN undefined: y = x; no saturation logic present.
// TESTING
//  1 K=32'h4000_0000, audio 0, dev_gain=0
//    -> phase +0x4000_0000 per clk; tx_out period 4 clk, 50% duty; underrun pulses every en32k.
//  2 Continuous audio 16384, dev_gain=1, K=32'h4000_0000
//    -> steady baseband = 14400; freq_word = 32'h4038_4000; no underrun.
//  3 Hold audio_valid=0 through two en32k
//    -> underrun high exactly 1 cycle at each; comb input repeats the last sample.
//  4 valid asserted only in the en32k cycle with the register empty
//    -> bypass; ready stays 1; no underrun.
//    Then valid held high 2 cycles -> second sample stalls with ready=0 until the next en32k.
//  5 Assert reset (low) mid-stream at an arbitrary clk
//    -> all outputs and state 0 and ready=1 immediately, clk not required.
//    After release, first sample reproduces case 2 from the cold-start response.
//  6 PREEMPHASIS_EN, step 0 -> 16384
//    -> first comb input 32767 (saturated), then 16384; undefined build -> 16384 both.

Source files
------------

// File: rtl/fm_modulator_core.sv
// -----------------------------------------------------------------------------
// fm_modulator_core
//
// FM transmit core. Accepts signed audio at the audio rate (en32k) through a
// one-entry valid/ready holding register. It interpolates that audio by R2 up to
// the base-band rate (en960k) with a 3rd-order CIC. The base-band value is then
// scaled by dev_gain and shifted left by dev_shl to form a frequency deviation.
// That deviation is added to the carrier constant K. The resulting frequency
// word drives a full-rate phase accumulator. The registered accumulator MSB is
// the 1-bit carrier.
//
// Optional feature macro: PREEMPHASIS_EN
//   When defined, a first-order high-shelf pre-emphasis is applied to each sample
//   entering the comb: y = sat(x + ((x - x_prev) <<< 1)). When undefined, y = x.
//
// Ports
//   clk          in   system clock
//   reset        in   asynchronous, active-low reset
//   en960k       in   base-band clock enable (one-cycle pulse)
//   en32k        in   audio clock enable, always coincides with en960k
//   audio_in     in   signed audio sample
//   audio_valid  in   audio_in valid
//   audio_ready  out  holding register empty
//   K            in   carrier phase constant
//   dev_gain     in   unsigned deviation gain
//   phase        out  phase accumulator
//   tx_out       out  registered phase MSB, the 1-bit carrier
//   underrun     out  one-cycle pulse when en32k found no sample
// -----------------------------------------------------------------------------
module fm_modulator_core #(
   parameter int width_dds   = 32,
   parameter int width_audio = 16,
   parameter int R2          = 30,
   parameter int dev_shl     = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   en960k,
   input  logic                   en32k,
   input  logic [width_audio-1:0] audio_in,
   input  logic                   audio_valid,
   output logic                   audio_ready,
   input  logic [width_dds-1:0]   K,
   input  logic [7:0]             dev_gain,
   output logic [width_dds-1:0]   phase,
   output logic                   tx_out,
   output logic                   underrun
);

   localparam int CIC_W  = width_audio + 3 * $clog2(R2);
   localparam int SHIFT  = $clog2(R2 * R2);
   localparam int PROD_W = width_audio + 9;

   logic                     r_holdFull;
   logic [width_audio-1:0]   r_holdData;
   logic [width_audio-1:0]   r_lastSample;
   logic                     r_underrun;
   logic signed [CIC_W-1:0]  r_d1, r_d2, r_d3, r_combOut;
   logic signed [CIC_W-1:0]  r_i1, r_i2, r_i3;
   logic                     r_pend;
   logic [width_dds-1:0]     r_freqWord;
   logic [width_dds-1:0]     r_phase;
   logic                     r_tx;

   logic [width_audio-1:0]   w_xIn;
   logic                     w_underrunNext;
   logic [width_audio-1:0]   w_combIn;
   logic signed [CIC_W-1:0]  w_c0, w_c1, w_c2, w_c3;
   logic [width_audio-1:0]   w_baseband;
   logic signed [PROD_W-1:0] w_bbExt, w_gainExt, w_prod;
   logic [width_dds-1:0]     w_dev;

   assign audio_ready = ~r_holdFull;
   assign phase       = r_phase;
   assign tx_out      = r_tx;
   assign underrun    = r_underrun;

   // Choose the sample handed to the comb on en32k: the held sample if there
   // is one, otherwise a sample arriving this very cycle (bypass), otherwise
   // repeat the previous one and flag an underrun.
   always_comb begin
      w_xIn          = r_lastSample;
      w_underrunNext = 1'b0;
      if (r_holdFull) begin
         w_xIn = r_holdData;
      end else if (audio_valid) begin
         w_xIn = audio_in;
      end else begin
         w_underrunNext = en32k;
      end
   end

`ifdef PREEMPHASIS_EN
   logic signed [width_audio+2:0] w_xExt, w_pExt, w_emph;

   // High-shelf pre-emphasis, x_prev is the previous unemphasised sample.
   // Three guard bits hold the worst case 3x - 2x_prev; the top four bits all
   // equal means the result fits width_audio, otherwise clamp by sign.
   always_comb begin
      w_xExt = {{3{w_xIn[width_audio-1]}}, w_xIn};
      w_pExt = {{3{r_lastSample[width_audio-1]}}, r_lastSample};
      w_emph = w_xExt + ((w_xExt - w_pExt) <<< 1);
      if (w_emph[width_audio+2:width_audio-1] == {4{w_emph[width_audio+2]}}) begin
         w_combIn = w_emph[width_audio-1:0];
      end else if (w_emph[width_audio+2]) begin
         w_combIn = {1'b1, {(width_audio-1){1'b0}}};
      end else begin
         w_combIn = {1'b0, {(width_audio-1){1'b1}}};
      end
   end
`else
   assign w_combIn = w_xIn;
`endif

   // Comb chain, differential delay 1, evaluated combinationally from the
   // delay registers and captured on en32k.
   always_comb begin
      w_c0 = {{(CIC_W-width_audio){w_combIn[width_audio-1]}}, w_combIn};
      w_c1 = w_c0 - r_d1;
      w_c2 = w_c1 - r_d2;
      w_c3 = w_c2 - r_d3;
   end

   // Baseband is integ3 arithmetically shifted down by S and truncated; the
   // product with the zero-extended gain is signed, then sign-extended and
   // shifted into deviation units.
   always_comb begin
      w_baseband = width_audio'(r_i3 >>> SHIFT);
      w_bbExt    = {{(PROD_W-width_audio){w_baseband[width_audio-1]}}, w_baseband};
      w_gainExt  = {{(PROD_W-8){1'b0}}, dev_gain};
      w_prod     = w_bbExt * w_gainExt;
      w_dev      = {{(width_dds-PROD_W){w_prod[PROD_W-1]}}, w_prod} << dev_shl;
   end

   // Holding register. On en32k the content always leaves for the comb; a
   // sample presented in that same cycle is captured only if the register was
   // full (otherwise it has already bypassed to the comb).
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_holdFull   <= 1'b0;
         r_holdData   <= '0;
         r_lastSample <= '0;
         r_underrun   <= 1'b0;
      end else begin
         r_underrun <= w_underrunNext;
         if (en32k) begin
            r_lastSample <= w_xIn;
            r_holdFull   <= r_holdFull & audio_valid;
            if (r_holdFull && audio_valid) begin
               r_holdData <= audio_in;
            end
         end else if (audio_valid && !r_holdFull) begin
            r_holdData <= audio_in;
            r_holdFull <= 1'b1;
         end
      end
   end

   // Comb delay line and registered comb result, audio rate.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_d1      <= '0;
         r_d2      <= '0;
         r_d3      <= '0;
         r_combOut <= '0;
      end else if (en32k) begin
         r_d1      <= w_c0;
         r_d2      <= w_c1;
         r_d3      <= w_c2;
         r_combOut <= w_c3;
      end
   end

   // Integrators at base-band rate. r_pend marks the first en960k after an
   // en32k so the comb result is injected once (zero-stuffing the rest).
   // Two's-complement wrap is relied upon.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_pend     <= 1'b0;
         r_i1       <= '0;
         r_i2       <= '0;
         r_i3       <= '0;
         r_freqWord <= '0;
      end else if (en960k) begin
         r_pend     <= en32k;
         r_i1       <= r_i1 + (r_pend ? r_combOut : '0);
         r_i2       <= r_i2 + r_i1;
         r_i3       <= r_i3 + r_i2;
         r_freqWord <= K + w_dev;
      end
   end

   // Full-rate phase accumulator; carrier is the previous phase MSB.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_phase <= '0;
         r_tx    <= 1'b0;
      end else begin
         r_phase <= r_phase + r_freqWord;
         r_tx    <= r_phase[width_dds-1];
      end
   end

endmodule

// File: tb/tb_fm_modulator_core.sv
// -----------------------------------------------------------------------------
// tb_fm_modulator_core
//
// Bench for fm_modulator_core. Each driven cycle pushes the expected ready,
// underrun, phase, carrier and optional frequency-word delta onto a scoreboard
// queue; a monitor pops one entry after every rising edge and compares.
// -----------------------------------------------------------------------------
module tb_fm_modulator_core;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        en960k = 1'b0;
   logic        en32k = 1'b0;
   logic [15:0] audio_in = '0;
   logic        audio_valid = 1'b0;
   logic        audio_ready;
   logic [31:0] K = '0;
   logic [7:0]  dev_gain = '0;
   logic [31:0] phase;
   logic        tx_out;
   logic        underrun;

`ifdef PREEMPHASIS_EN
   localparam logic [31:0] COLD_FREQ = 32'h4000_1F00;
`else
   localparam logic [31:0] COLD_FREQ = 32'h4000_1000;
`endif
   localparam logic [31:0] STEADY_FREQ = 32'h4038_4000;
   localparam logic [31:0] CARRIER_K   = 32'h4000_0000;

   typedef struct {
      logic        chkPhase;
      logic [31:0] phase;
      logic        tx;
      logic        ready;
      logic        underrun;
      logic        chkDelta;
      logic [31:0] delta;
   } expect_t;

   expect_t     sbQ[$];
   int          checkCount = 0;
   int          errorCount = 0;
   int          clkCount = 0;
   logic [7:0]  gainSet = '0;
   logic [31:0] kSet = '0;
   logic        mFull = 1'b0;
   logic [31:0] mPhase = '0;
   logic [31:0] mFreq = '0;
   logic        mTx = 1'b0;
   logic        mKnown = 1'b1;
   logic [31:0] prevPhase = '0;

   fm_modulator_core dut (
      .clk         (clk),
      .reset       (reset),
      .en960k      (en960k),
      .en32k       (en32k),
      .audio_in    (audio_in),
      .audio_valid (audio_valid),
      .audio_ready (audio_ready),
      .K           (K),
      .dev_gain    (dev_gain),
      .phase       (phase),
      .tx_out      (tx_out),
      .underrun    (underrun)
   );

   // 10 ns clock; en960k every 4 clocks, en32k every 30 en960k pulses.
   initial begin
      forever #5 clk = ~clk;
   end

   // Single comparison point for the whole bench.
   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
      end
   endtask

   function automatic bit next32k();
      return ((clkCount + 1) % 120) == 0;
   endfunction

   // Drives one cycle at the falling edge and pushes what the outputs must
   // look like after the following rising edge.
   task automatic applyStimulus(input logic v, input logic [15:0] a,
                                input logic chkD, input logic [31:0] expD);
      expect_t e;
      @(negedge clk);
      clkCount++;
      en960k      = (clkCount % 4) == 0;
      en32k       = (clkCount % 120) == 0;
      audio_valid = v;
      audio_in    = a;
      K           = kSet;
      dev_gain    = gainSet;
      if (!reset) begin
         mFull      = 1'b0;
         mPhase     = '0;
         mFreq      = '0;
         mTx        = 1'b0;
         mKnown     = 1'b1;
         e.underrun = 1'b0;
      end else begin
         e.underrun = en32k && !mFull && !v;
         mFull      = en32k ? (mFull && v) : (mFull || v);
         mTx        = mPhase[31];
         mPhase     = mPhase + mFreq;
         if (en960k) begin
            if (gainSet == 8'd0) mFreq = kSet;
            else mKnown = 1'b0;
         end
      end
      e.ready    = !mFull;
      e.chkPhase = mKnown;
      e.phase    = mPhase;
      e.tx       = mTx;
      e.chkDelta = chkD;
      e.delta    = expD;
      sbQ.push_back(e);
   endtask

   // Monitor: one scoreboard entry per rising edge, sampled 1 ns later.
   initial begin
      expect_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            checkOutput("ready", {31'd0, audio_ready}, {31'd0, e.ready});
            checkOutput("underrun", {31'd0, underrun}, {31'd0, e.underrun});
            if (e.chkPhase) begin
               checkOutput("phase", phase, e.phase);
               checkOutput("txOut", {31'd0, tx_out}, {31'd0, e.tx});
            end
            if (e.chkDelta) begin
               checkOutput("freqWord", phase - prevPhase, e.delta);
            end
         end
         prevPhase = phase;
      end
   end

   initial begin
      kSet    = CARRIER_K;
      gainSet = 8'd0;
      #1 reset = 1'b0;
      #1;
      checkOutput("rstPhase", phase, 32'd0);
      checkOutput("rstTx", {31'd0, tx_out}, 32'd0);
      checkOutput("rstUnderrun", {31'd0, underrun}, 32'd0);
      checkOutput("rstReady", {31'd0, audio_ready}, 32'd1);
      repeat (6) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;

      $display("[TB] carrier only, no audio");
      repeat (260) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);

      $display("[TB] bypass and stall");
      while (!next32k()) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 16'h1234, 1'b0, 32'd0);
      repeat (10) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
      applyStimulus(1'b1, 16'h0555, 1'b0, 32'd0);
      while (!next32k()) applyStimulus(1'b1, 16'h0AAA, 1'b0, 32'd0);
      applyStimulus(1'b1, 16'h0AAA, 1'b0, 32'd0);
      repeat (130) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);

      $display("[TB] continuous audio 16384");
      gainSet = 8'd1;
      repeat (14 * 120) applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      for (int i = 0; i < 40; i++) begin
         applyStimulus(1'b1, 16'd16384, (i % 10) == 0, STEADY_FREQ);
      end

      $display("[TB] audio stops, last sample repeats");
      for (int i = 0; i < 360; i++) begin
         applyStimulus(1'b0, 16'd0, (i % 40) == 0, STEADY_FREQ);
      end

      $display("[TB] reset mid-stream");
      repeat (50) applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      #1;
      checkOutput("midRstPhase", phase, 32'd0);
      checkOutput("midRstTx", {31'd0, tx_out}, 32'd0);
      checkOutput("midRstUnderrun", {31'd0, underrun}, 32'd0);
      checkOutput("midRstReady", {31'd0, audio_ready}, 32'd1);
      repeat (3) applyStimulus(1'b0, 16'd0, 1'b0, 32'd0);
      @(posedge clk);
      #3 reset = 1'b1;

      $display("[TB] cold start response");
      while (!next32k()) applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      for (int j = 1; j <= 20; j++) begin
         if (j == 16) applyStimulus(1'b1, 16'd16384, 1'b1, CARRIER_K);
         else if (j == 17) applyStimulus(1'b1, 16'd16384, 1'b1, COLD_FREQ);
         else applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      end
      repeat (14 * 120) applyStimulus(1'b1, 16'd16384, 1'b0, 32'd0);
      for (int i = 0; i < 30; i++) begin
         applyStimulus(1'b1, 16'd16384, (i % 10) == 0, STEADY_FREQ);
      end

      @(posedge clk);
      #2;
      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
